// File: rtl/core_pkg.sv
// Shared types and defaults for the memory/write-back stage.
package core_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int RD_W_DEF        = 6;
  localparam int MEM_TIMEOUT_DEF = 255;

  // Register index 0 is hard-wired zero; writes to it are dropped.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STORE  = 2'd1,
    COMMIT = 2'd2
  } memwb_state_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_write_back_if.sv
// Execute-to-write-back result channel: valid/ready handshake plus the result fields.
// A transfer happens on a rising edge where ex_valid and ex_ready are both 1; the master
// holds every field stable while ex_valid is high and ex_ready is low.
interface mem_write_back_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] data;
  logic              mem_write_enabled;
  logic [DATA_W-1:0] mem_write_dest;
  logic              reg_write_enabled;
  logic [RD_W-1:0]   reg_write_dest;
  logic              is_jump_enabled;
  logic [DATA_W-1:0] jump_dest;

  modport master (
    output ex_valid, data, mem_write_enabled, mem_write_dest,
           reg_write_enabled, reg_write_dest, is_jump_enabled, jump_dest,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, data, mem_write_enabled, mem_write_dest,
           reg_write_enabled, reg_write_dest, is_jump_enabled, jump_dest,
    output ex_ready
  );
endinterface

// File: rtl/mem_store_port.sv
// Data-memory store port: holds req/we/addr/wdata until ack, abandons after MEM_TIMEOUT cycles.
module mem_store_port #(
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              dmem_ack_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic              req_q, req_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_cycle;

  // cnt_q counts completed request cycles, so the request is live for exactly MEM_TIMEOUT cycles.
  assign last_cycle = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    if (req_q) begin
      done_o    = dmem_ack_i | last_cycle;
      timeout_o = last_cycle & ~dmem_ack_i;
      cnt_d     = cnt_q + CNT_W'(1);
      if (done_o) begin
        req_d = 1'b0;
        cnt_d = '0;
      end
    end else if (start_i) begin
      req_d   = 1'b1;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = req_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_write_back.sv
// Memory/write-back stage: accepts one execute result, performs its store, then commits the
// register write and PC redirect together. Optional retire counter under MEMWB_RETIRE_CNT_EN.
module mem_write_back
  import core_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RD_W        = RD_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  mem_write_back_if.slave   ex,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              mem_error,
  output memwb_state_t      dbg_state_o
`ifdef MEMWB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_count
`endif
);

  memwb_state_t state_q, state_d;

  logic [DATA_W-1:0] data_q;
  logic              rw_q;
  logic [RD_W-1:0]   rd_q;
  logic              jmp_q;
  logic [DATA_W-1:0] jdest_q;

  logic              lat_en, st_start, st_done, st_timeout;
  logic              err_set, go_commit, sel_in;
  logic              mem_error_q;

  logic              eff_rw, eff_jmp;
  logic [RD_W-1:0]   eff_rd;
  logic [DATA_W-1:0] eff_data, eff_jdest;

  logic              rf_we_q, rf_we_d;
  logic [RD_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              redir_q, redir_d;
  logic [DATA_W-1:0] redir_pc_q, redir_pc_d;

  mem_store_port #(
    .DATA_W      (DATA_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_store (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (st_start),
    .addr_i       (ex.mem_write_dest),
    .wdata_i      (ex.data),
    .dmem_ack_i   (dmem_ack),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .done_o       (st_done),
    .timeout_o    (st_timeout)
  );

  assign ex.ex_ready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    lat_en    = 1'b0;
    st_start  = 1'b0;
    err_set   = 1'b0;
    go_commit = 1'b0;
    sel_in    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex.ex_valid) begin
          lat_en = 1'b1;
          if (ex.mem_write_enabled && is_word_aligned(ex.mem_write_dest[1:0])) begin
            st_start = 1'b1;
            state_d  = STORE;
          end else begin
            // Misaligned stores are flagged and dropped; the rest of the result still commits.
            err_set   = ex.mem_write_enabled;
            go_commit = 1'b1;
            sel_in    = 1'b1;
            state_d   = COMMIT;
          end
        end
      end
      STORE: begin
        if (st_done) begin
          err_set   = st_timeout;
          go_commit = 1'b1;
          state_d   = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A non-store commits straight from the accepting cycle, so read the live inputs there.
  assign eff_rw    = sel_in ? ex.reg_write_enabled : rw_q;
  assign eff_rd    = sel_in ? ex.reg_write_dest    : rd_q;
  assign eff_data  = sel_in ? ex.data              : data_q;
  assign eff_jmp   = sel_in ? ex.is_jump_enabled   : jmp_q;
  assign eff_jdest = sel_in ? ex.jump_dest         : jdest_q;

  always_comb begin
    rf_we_d    = go_commit & eff_rw & (eff_rd != RD_W'(REG_ZERO));
    rf_waddr_d = go_commit ? eff_rd : '0;
    rf_wdata_d = go_commit ? eff_data : '0;
    redir_d    = go_commit & eff_jmp;
    redir_pc_d = (go_commit & eff_jmp) ? eff_jdest : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rw_q        <= 1'b0;
      rd_q        <= '0;
      jmp_q       <= 1'b0;
      jdest_q     <= '0;
      mem_error_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      redir_q     <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      state_q <= state_d;
      if (lat_en) begin
        data_q  <= ex.data;
        rw_q    <= ex.reg_write_enabled;
        rd_q    <= ex.reg_write_dest;
        jmp_q   <= ex.is_jump_enabled;
        jdest_q <= ex.jump_dest;
      end
      mem_error_q <= mem_error_q | err_set;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      redir_q     <= redir_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  assign mem_error      = mem_error_q;
  assign dbg_state_o    = state_q;

`ifdef MEMWB_RETIRE_CNT_EN
  logic [63:0] retire_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_q <= '0;
    end else if (state_q == COMMIT) begin
      retire_q <= retire_q + 64'd1;
    end
  end

  assign retire_count = retire_q;
`endif

endmodule
